// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low patterns and codes.
// Hex entries A-F are only treated as legal when SEG7_HEX_DECODE_EN is defined.
package seg7_pkg;

   localparam logic [6:0] PAT_0 = 7'b1000000;
   localparam logic [6:0] PAT_1 = 7'b1111001;
   localparam logic [6:0] PAT_2 = 7'b0100100;
   localparam logic [6:0] PAT_3 = 7'b0110000;
   localparam logic [6:0] PAT_4 = 7'b0011001;
   localparam logic [6:0] PAT_5 = 7'b0010010;
   localparam logic [6:0] PAT_6 = 7'b0000010;
   localparam logic [6:0] PAT_7 = 7'b1111000;
   localparam logic [6:0] PAT_8 = 7'b0000000;
   localparam logic [6:0] PAT_9 = 7'b0010000;

   localparam logic [6:0] PAT_A = 7'b0001000;
   localparam logic [6:0] PAT_B = 7'b0000011;
   localparam logic [6:0] PAT_C = 7'b1000110;
   localparam logic [6:0] PAT_D = 7'b0100001;
   localparam logic [6:0] PAT_E = 7'b0000110;
   localparam logic [6:0] PAT_F = 7'b0001110;

   localparam logic [6:0] PAT_BLANK    = 7'b1111111;
   localparam logic [3:0] CODE_INVALID = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational pattern-to-code lookup for one digit.
// Hex letters are decoded only when SEG7_HEX_DECODE_EN is defined.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic       legal,
   output logic [3:0] code
);

   always_comb begin
      legal = 1'b1;
      code  = CODE_INVALID;
      case (pat)
         PAT_0: code = 4'h0;
         PAT_1: code = 4'h1;
         PAT_2: code = 4'h2;
         PAT_3: code = 4'h3;
         PAT_4: code = 4'h4;
         PAT_5: code = 4'h5;
         PAT_6: code = 4'h6;
         PAT_7: code = 4'h7;
         PAT_8: code = 4'h8;
         PAT_9: code = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
         PAT_A: code = 4'hA;
         PAT_B: code = 4'hB;
         PAT_C: code = 4'hC;
         PAT_D: code = 4'hD;
         PAT_E: code = 4'hE;
         PAT_F: code = 4'hF;
`endif
         default: begin
            legal = 1'b0;
            code  = CODE_INVALID;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed 7-segment display and recovers a stable code per digit.
// Optional hex letters via SEG7_HEX_DECODE_EN (see seg7_pattern_decode).
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int STABLE_CNT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   input  logic                    sample_tick,
   input  logic                    err_clr,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    err_pattern,
   output logic                    err_sel
);

   localparam logic [3:0]            SAT = 4'(STABLE_CNT);
   localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

   logic                  sel_ok;
   logic [NUM_DIGITS-1:0] commit;
   logic [NUM_DIGITS-1:0] bad;
   logic [NUM_DIGITS-1:0] done_mask;

   assign sel_ok = (dig_en != '0) && ((dig_en & (dig_en - ONE)) == '0);

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic [6:0] last_pat;
      logic [3:0] stab_cnt;
      logic       pend;
      logic [3:0] bcd_r;
      logic       valid_r;
      logic       hit;
      logic       same;
      logic       legal;
      logic [3:0] code;

      assign hit  = sample_tick && sel_ok && dig_en[i];
      assign same = (seg_in == last_pat);

      // last_pat still holds the completed pattern on the commit edge
      seg7_pattern_decode u_dec (
         .pat   (last_pat),
         .legal (legal),
         .code  (code)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            last_pat <= PAT_BLANK;
            stab_cnt <= 4'd0;
            pend     <= 1'b0;
            bcd_r    <= CODE_INVALID;
            valid_r  <= 1'b0;
         end else begin
            pend <= 1'b0;
            if (hit) begin
               if (same) begin
                  if (stab_cnt != SAT) begin
                     stab_cnt <= stab_cnt + 4'd1;
                     pend     <= (stab_cnt == SAT - 4'd1);
                  end
               end else begin
                  last_pat <= seg_in;
                  stab_cnt <= 4'd1;
                  pend     <= (SAT == 4'd1);
               end
            end
            if (pend) begin
               bcd_r   <= legal ? code : CODE_INVALID;
               valid_r <= legal;
            end
         end
      end

      assign bcd_out[4*i +: 4] = bcd_r;
      assign digit_valid[i]    = valid_r;
      assign commit[i]         = pend;
      assign bad[i]            = pend && !legal;
   end

   assign frame_done = &done_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_mask   <= '0;
         err_pattern <= 1'b0;
         err_sel     <= 1'b0;
      end else begin
         done_mask <= (frame_done ? '0 : done_mask) | commit;
         // a new error event outranks a simultaneous clear
         if (|bad)
            err_pattern <= 1'b1;
         else if (err_clr)
            err_pattern <= 1'b0;
         if (sample_tick && !sel_ok)
            err_sel <= 1'b1;
         else if (err_clr)
            err_sel <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed-vector bench for seg7_scan_decoder (NUM_DIGITS=6, STABLE_CNT=4).
// Build with +define+SEG7_HEX_DECODE_EN to check the hex-letter variant.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [5:0]  dig_en;
   logic        sample_tick;
   logic        err_clr;
   logic [23:0] bcd_out;
   logic [5:0]  digit_valid;
   logic        frame_done;
   logic        err_pattern;
   logic        err_sel;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   fd_cnt  = 0;
   int   fd_base;
   logic saw5    = 1'b0;
   logic [23:0] b0;
   logic [5:0]  v0;
   logic [6:0]  pats [6];

   always #5 clk = ~clk;

   seg7_scan_decoder #(
      .NUM_DIGITS (6),
      .STABLE_CNT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .dig_en      (dig_en),
      .sample_tick (sample_tick),
      .err_clr     (err_clr),
      .bcd_out     (bcd_out),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .err_pattern (err_pattern),
      .err_sel     (err_sel)
   );

   always @(posedge clk) begin
      if (frame_done) fd_cnt++;
      if (bcd_out[11:8] == 4'h5) saw5 = 1'b1;
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick_raw(logic [5:0] en, logic [6:0] p);
      dig_en      = en;
      seg_in      = p;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      dig_en      = '0;
   endtask

   task automatic tick(int d, logic [6:0] p);
      tick_raw(6'b000001 << d, p);
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      seg_in      = PAT_BLANK;
      dig_en      = '0;
      sample_tick = 1'b0;
      err_clr     = 1'b0;
      idle(2);
      check("rst_bcd", bcd_out, 24'hFFFFFF);
      check("rst_valid", digit_valid, 0);
      check("rst_fd", frame_done, 0);
      check("rst_errp", err_pattern, 0);
      check("rst_errs", err_sel, 0);
      rst_n = 1'b1;
      idle(1);

      // digit 0 shows "2"
      repeat (3) tick(0, PAT_2);
      idle(1);
      check("d0_early", bcd_out[3:0], 4'hF);
      tick(0, PAT_2);
      check("d0_latency", bcd_out[3:0], 4'hF);
      idle(1);
      check("d0_code", bcd_out[3:0], 4'h2);
      check("d0_valid", digit_valid[0], 1);

      // digit 2: unstable 5 then stable 6
      repeat (3) tick(2, PAT_5);
      repeat (4) tick(2, PAT_6);
      idle(1);
      check("d2_code", bcd_out[11:8], 4'h6);
      check("d2_no5", saw5, 0);

      // full frame "202412"
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      pats[0] = PAT_2; pats[1] = PAT_1; pats[2] = PAT_4;
      pats[3] = PAT_2; pats[4] = PAT_0; pats[5] = PAT_2;
      fd_base = fd_cnt;
      for (int r = 0; r < 4; r++)
         for (int d = 0; d < 6; d++)
            tick(d, pats[d]);
      idle(2);
      check("frame_bcd", bcd_out, 24'h202412);
      check("frame_valid", digit_valid, 6'h3F);
      check("frame_pulse", fd_cnt - fd_base, 1);
      for (int r = 0; r < 4; r++)
         for (int d = 0; d < 6; d++)
            tick(d, pats[d]);
      idle(3);
      check("frame_nopulse", fd_cnt - fd_base, 1);
      check("frame_fd_low", frame_done, 0);

      // select errors
      b0 = bcd_out;
      v0 = digit_valid;
      tick_raw(6'b000011, PAT_8);
      check("sel_multi", err_sel, 1);
      check("sel_bcd_hold", bcd_out, b0);
      check("sel_valid_hold", digit_valid, v0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("sel_clr", err_sel, 0);
      err_clr = 1'b1;
      tick_raw(6'b000000, PAT_8);
      err_clr = 1'b0;
      check("sel_clr_race", err_sel, 1);
      check("sel_no_errp", err_pattern, 0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;

      // hex letter A on digit 1
      repeat (4) tick(1, PAT_A);
      idle(1);
`ifdef SEG7_HEX_DECODE_EN
      check("hexA_code", bcd_out[7:4], 4'hA);
      check("hexA_valid", digit_valid[1], 1);
      check("hexA_errp", err_pattern, 0);
`else
      check("hexA_code", bcd_out[7:4], 4'hF);
      check("hexA_valid", digit_valid[1], 0);
      check("hexA_errp", err_pattern, 1);
`endif
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("errp_clr", err_pattern, 0);

      // held strobe: one sample per cycle
      dig_en      = 6'b010000;
      seg_in      = PAT_9;
      sample_tick = 1'b1;
      idle(4);
      sample_tick = 1'b0;
      dig_en      = '0;
      idle(1);
      check("burst_code", bcd_out[19:16], 4'h9);

      // reset mid-count
      repeat (2) tick(3, PAT_7);
      rst_n = 1'b0;
      #1;
      check("midrst_bcd", bcd_out, 24'hFFFFFF);
      check("midrst_valid", digit_valid, 0);
      check("midrst_errs", err_sel, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      repeat (3) tick(3, PAT_7);
      idle(1);
      check("midrst_early", bcd_out[15:12], 4'hF);
      tick(3, PAT_7);
      idle(1);
      check("midrst_code", bcd_out[15:12], 4'h7);
      check("midrst_dvalid", digit_valid[3], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 6, is the number of multiplexed display digits observed.
REQ-002 Parameter STABLE_CNT, default 4, is the number of identical consecutive samples required to commit a digit (range 1..15).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port seg_in, input, 7: segment pattern {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-006 Port dig_en, input, NUM_DIGITS: one-hot, active-high; marks which digit seg_in currently shows.
REQ-007 Port sample_tick, input, 1: single-cycle strobe; seg_in and dig_en are sampled only when it is high.
REQ-008 Port err_clr, input, 1: clears the sticky error flags.
REQ-009 Port bcd_out, output, 4*NUM_DIGITS: committed code per digit; digit i occupies bits [4i+3:4i].
REQ-010 Port digit_valid, output, NUM_DIGITS: 1 = bcd_out for that digit holds a legal decoded code.
REQ-011 Port frame_done, output, 1: one-cycle pulse when every digit has committed since the last pulse.
REQ-012 Port err_pattern, output, 1: sticky; an illegal pattern was committed.
REQ-013 Port err_sel, output, 1: sticky; a sample_tick arrived with dig_en not one-hot.

Function
REQ-014 Legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 On sample_tick with one-hot dig_en selecting digit i: if seg_in equals last_pat[i], stab_cnt[i] increments, saturating at STABLE_CNT; otherwise last_pat[i] <= seg_in and stab_cnt[i] <= 1.
REQ-016 When stab_cnt[i] first reaches STABLE_CNT, digit i commits on the next clock edge (latency: one clock after the completing tick).
REQ-017 A commit of a legal pattern writes its code to bcd_out[i] and sets digit_valid[i] to 1.
REQ-018 A commit of an illegal pattern writes 4'hF to bcd_out[i], clears digit_valid[i], and sets err_pattern.
REQ-019 A digit that remains saturated does not recommit; a changed pattern restarts counting, and the old committed value is held until the new commit.
REQ-020 A tick with dig_en all-zero or multi-hot sets err_sel and changes no per-digit state.
REQ-021 A per-digit done mask sets on commit; when the mask is all-ones, frame_done pulses for one cycle and the mask clears in that same cycle.
REQ-022 When a commit of digit j coincides with the mask clear, the mask becomes {bit j only}.
REQ-023 When err_clr and a new error event occur in the same cycle, the error wins and the flag stays 1.
REQ-024 A sample_tick asserted for multiple consecutive cycles counts as one sample per cycle; no edge detection is performed.

Reset
REQ-025 When rst_n is low: bcd_out = all 4'hF, digit_valid = 0, frame_done = 0, err_pattern = 0, err_sel = 0, stab_cnt = 0, last_pat = 7'b1111111, done mask = 0.
REQ-026 Reset asserted mid-count discards partial stability state; after release, counting restarts from zero.

Configuration
REQ-027 Macro SEG7_HEX_DECODE_EN defined: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 are legal and decode to 4'hA..4'hF; F is then reported with digit_valid = 1.
REQ-028 Macro SEG7_HEX_DECODE_EN undefined: those six patterns are illegal and are handled per REQ-018.

Structure
REQ-029 Package seg7_pkg shall hold the active-low pattern constants for 0-9 and A-F, the blank pattern, and the invalid code constant 4'hF.
REQ-030 Sub-module seg7_pattern_decode shall be combinational, map a 7-bit pattern to {legal, code[3:0]}, and contain the macro-controlled hex entries.

Verification
REQ-031 NUM_DIGITS=6, STABLE_CNT=4; digit 0 given 0100100 for 4 ticks -> one cycle after the 4th tick, bcd_out[3:0]=2 and digit_valid[0]=1.
REQ-032 Digit 2 given 0010010 for 3 ticks, then 0000010 for 4 ticks -> bcd_out[11:8] never shows 5 and becomes 6.
REQ-033 Six digits given "202412" stable -> bcd_out = 0x202412, single frame_done pulse; continued identical ticks -> no further pulse.
REQ-034 dig_en=6'b000011 with tick -> err_sel=1 and no state change; err_clr -> err_sel=0; err_clr concurrent with a new bad tick -> err_sel stays 1.
REQ-035 Pattern 0001000 stable -> without macro: err_pattern=1 and code 4'hF; with SEG7_HEX_DECODE_EN: code 4'hA and digit_valid=1.
REQ-036 rst_n low after 2 of 4 ticks -> outputs at reset values; 4 further ticks are needed to commit.
